exec_muldiv: RTL
================

// Module: exec_muldiv
// PURPOSE
//  Parametrised multi-cycle execute unit for the RV32M extension: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
//  Sits beside the ALU/FPU in the execute stage; accepts one op via valid/ready and returns a tagged result
//  via valid/ready. Multiply latency is fixed and configurable; divide is iterative (radix-2, 1 bit/cycle).
//  Supports flush from a taken branch/jump and output backpressure; one op in flight at a time.
// PARAMETERS
//  XLEN         32  operand/result width (>=8, even)
//  MUL_LATENCY  2   cycles from accept to out_valid for MUL* ops (1..4)
//  TAG_W        5   width of opaque tag (dest reg id) carried with the op
// PORTS
//  clk         in   1        clock, all state on posedge
//  rst         in   1        synchronous reset, active-high
//  in_valid    in   1        op presented
//  in_ready    out  1        unit can accept an op this cycle
//  in_op       in   3        funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  in_rs1      in   XLEN     operand a (dividend / multiplicand)
//  in_rs2      in   XLEN     operand b (divisor / multiplier)
//  in_tag      in   TAG_W    returned unchanged with result
//  flush       in   1        kill in-flight op and any held result
//  out_valid   out  1        result available
//  out_ready   in   1        consumer takes result
//  out_result  out  XLEN     result
//  out_tag     out  TAG_W    tag of the op
//  busy        out  1        state != IDLE
// BEHAVIOUR
//  Reset: state IDLE; out_valid=0, out_result=0, out_tag=0, busy=0, counters 0. Reset mid-op discards op.
//  in_ready = !flush && (state==IDLE || (state==DONE && out_ready)). Accept = in_valid && in_ready;
//   operands, op and tag latched at accept; inputs ignored afterwards.
//  FSM: IDLE -accept MUL*-> MUL; IDLE -accept DIV*/REM* (normal)-> DIV; -accept div special-> DONE;
//   MUL -count hits MUL_LATENCY-1-> DONE; DIV -XLEN iterations-> FIX; FIX -> DONE;
//   DONE -out_ready && !accept-> IDLE; DONE -out_ready && accept-> MUL/DIV/DONE as from IDLE.
//  Latency (accept at cycle N): MUL* out_valid at N+MUL_LATENCY; DIV* normal at N+XLEN+2; special at N+1.
//  Multiply: 2*XLEN product of sign/zero-extended operands (MULH: s*s, MULHSU: s*u, MULHU: u*u);
//   MUL returns low XLEN bits, MULH* high XLEN bits. Product may be pipelined across MUL stages.
//  Divide: operate on magnitudes (signed ops) in restoring form, one quotient bit per DIV cycle;
//   FIX negates quotient if signs differ, remainder takes sign of dividend.
//  Special cases decided at accept, no iteration:
//   divisor 0: DIV/DIVU -> all ones; REM/REMU -> rs1.
//   signed overflow (rs1 = 1<<(XLEN-1), rs2 = all ones): DIV -> rs1; REM -> 0.
//  DONE: out_valid=1, out_result/out_tag stable until out_ready sampled high; no drop, no duplicate.
//  flush (highest priority): next cycle state IDLE, out_valid=0; op presented in a flush cycle is not accepted
//   (in_ready=0). Flush while IDLE is a no-op. rst overrides flush.
//  out_valid deasserts the cycle after handoff unless a back-to-back special op completes then.
// TESTING (XLEN=32, MUL_LATENCY=2)
//  MUL 7 * 0xFFFFFFFD, tag 3, accept N -> out_valid at N+2, result 0xFFFFFFEB, tag 3; MULHU 0xFFFFFFFF^2 -> 0xFFFFFFFE.
//  MULH 0x80000000*0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
//  DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD at N+34, busy high N+1..N+34; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14.
//  DIVU x/0 -> 0xFFFFFFFF at N+1; REMU 0x1234/0 -> 0x1234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
//  out_ready low 5 cycles in DONE -> result/tag held, in_ready 0; out_ready high with in_valid -> back-to-back accept.
//  flush at N+10 of DIV -> out_valid never rises, IDLE at N+11; rst at N+5 -> all outputs 0 next cycle.

Source files
------------

// File: rtl/exec_muldiv.sv
// exec_muldiv: RV32M multiply/divide execute unit with valid/ready handshakes, one op in flight
module exec_muldiv #(
    parameter int XLEN        = 32,
    parameter int MUL_LATENCY = 2,
    parameter int TAG_W       = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d, rem_q, rem_d, res_q, res_d;
    logic              neg_q_q, neg_q_d, neg_r_q, neg_r_d;
    logic [XLEN:0]     trial;
    logic              accept, sgn, neg_a, neg_b, dz, ovf;
    logic [XLEN-1:0]   spec_res, abs_a, abs_b;

    // Full-width product of extended operands; low half for MUL, high half otherwise
    function automatic logic [XLEN-1:0] mul_res(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic [2*XLEN-1:0] sa, sb, p;
        sa = {{XLEN{(op[1] ^ op[0]) & a[XLEN-1]}}, a};
        sb = {{XLEN{(op == 2'd1) & b[XLEN-1]}}, b};
        p  = sa * sb;
        return (op == 2'd0) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    assign in_ready   = !flush && (state_q == IDLE || (state_q == DONE && out_ready));
    assign accept     = in_valid && in_ready;
    assign out_valid  = state_q == DONE;
    assign out_result = res_q;
    assign out_tag    = tag_q;
    assign busy       = state_q != IDLE;

    // DIV/REM (even funct3) are signed; divide-by-zero and overflow resolve without iterating
    assign sgn      = !in_op[0];
    assign neg_a    = sgn & in_rs1[XLEN-1];
    assign neg_b    = sgn & in_rs2[XLEN-1];
    assign abs_a    = neg_a ? -in_rs1 : in_rs1;
    assign abs_b    = neg_b ? -in_rs2 : in_rs2;
    assign dz       = in_rs2 == '0;
    assign ovf      = sgn && in_rs1 == {1'b1, {(XLEN-1){1'b0}}} && &in_rs2;
    assign spec_res = dz ? (in_op[1] ? in_rs1 : '1) : (in_op[1] ? '0 : in_rs1);

    // Next state: advance the current op, then a new accept, then flush overrides everything
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        tag_d   = tag_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        res_d   = res_q;
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
        trial   = {rem_q, a_q[XLEN-1]} - {1'b0, b_q};
        if (state_q == MUL) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(MUL_LATENCY - 1)) begin
                state_d = DONE;
                res_d   = mul_res(op_q, a_q, b_q);
            end
        end else if (state_q == DIV) begin
            cnt_d = cnt_q + 1'b1;
            rem_d = trial[XLEN] ? {rem_q[XLEN-2:0], a_q[XLEN-1]} : trial[XLEN-1:0];
            a_d   = {a_q[XLEN-2:0], ~trial[XLEN]};
            if (cnt_q == CW'(XLEN - 1)) state_d = FIX;
        end else if (state_q == FIX) begin
            state_d = DONE;
            res_d   = op_q[1] ? (neg_r_q ? -rem_q : rem_q) : (neg_q_q ? -a_q : a_q);
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
        if (accept) begin
            op_d  = in_op[1:0];
            tag_d = in_tag;
            cnt_d = '0;
            if (!in_op[2]) begin
                a_d     = in_rs1;
                b_d     = in_rs2;
                cnt_d   = CW'(1);
                state_d = (MUL_LATENCY == 1) ? DONE : MUL;
                res_d   = (MUL_LATENCY == 1) ? mul_res(in_op[1:0], in_rs1, in_rs2) : res_q;
            end else if (dz || ovf) begin
                state_d = DONE;
                res_d   = spec_res;
            end else begin
                state_d = DIV;
                a_d     = abs_a;
                b_d     = abs_b;
                rem_d   = '0;
                neg_q_d = neg_a ^ neg_b;
                neg_r_d = neg_a;
            end
        end
        if (flush) state_d = IDLE;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            tag_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            res_q   <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            tag_q   <= tag_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            res_q   <= res_d;
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
        end
    end
endmodule
